// File: rtl/da2_controller_pkg.sv
// -----------------------------------------------------------------------------
// da2_controller_pkg
// Shared definitions for the Pmod DA2 transmit controller: frame width,
// DAC121S101 power-down codes, FSM state encoding and the frame builder.
// -----------------------------------------------------------------------------
package da2_controller_pkg;

  localparam int DA2_FRAME_W = 16;

  // DAC121S101 power-down modes (PD1:PD0)
  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Frame layout on the wire, MSB first: two don't-care zeros, PD bits, code.
  function automatic logic [DA2_FRAME_W-1:0] make_frame(input logic [1:0]  mode,
                                                        input logic [11:0] code);
    return {2'b00, mode, code};
  endfunction

endpackage

// File: rtl/da2_controller_if.sv
// -----------------------------------------------------------------------------
// da2_controller_if
// Request/response and serial-line bundle of the DA2 controller.
//   start        request a frame (sampled only while busy=0)
//   data1/data2  12-bit DAC codes, latched on accepted start
//   mode         PD1:PD0 power-down bits, latched on accepted start
//   busy         frame + gap in progress
//   done         one-cycle pulse at end of frame
//   sync         DAC frame sync, active low
//   sclk         serial clock, idles high
//   din1/din2    serial data for the two DACs
// master: the requester/observer side. slave: the controller.
// -----------------------------------------------------------------------------
interface da2_controller_if;
  logic        start;
  logic [11:0] data1;
  logic [11:0] data2;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic        sync;
  logic        sclk;
  logic        din1;
  logic        din2;

  modport master (
    output start, data1, data2, mode,
    input  busy, done, sync, sclk, din1, din2
  );

  modport slave (
    input  start, data1, data2, mode,
    output busy, done, sync, sclk, din1, din2
  );
endinterface

// File: rtl/da2_sclk_gen.sv
// -----------------------------------------------------------------------------
// da2_sclk_gen
// Serial clock generator for the DA2 link. While enabled, SCLK spends CLK_DIV
// cycles high then CLK_DIV cycles low, starting high. While disabled it is
// held high and the half-period counter is cleared, so every enable window
// begins with a full high phase.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   en_i    run the clock
//   sclk_o  serial clock (registered)
//   rise_o  one-cycle strobe: SCLK rises at the next edge (end of a bit)
//   fall_o  one-cycle strobe: SCLK falls at the next edge (DAC sample point)
// -----------------------------------------------------------------------------
module da2_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            HW   = $clog2(CLK_DIV) + 1;
  localparam logic [HW-1:0] HMAX = HW'(CLK_DIV - 1);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          sclk_q, sclk_d;
  logic          half_end;

  assign half_end = en_i && (hcnt_q == HMAX);
  assign rise_o   = half_end && !sclk_q;
  assign fall_o   = half_end &&  sclk_q;
  assign sclk_o   = sclk_q;

  always_comb begin
    hcnt_d = hcnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      hcnt_d = '0;
      sclk_d = 1'b1;
    end else if (half_end) begin
      hcnt_d = '0;
      sclk_d = !sclk_q;
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt_q <= '0;
      sclk_q <= 1'b1;
    end else begin
      hcnt_q <= hcnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/da2_controller.sv
// -----------------------------------------------------------------------------
// da2_controller
// Transmit controller for a Pmod DA2 (dual DAC121S101). On an accepted start
// it sends two 16-bit frames {2'b00, MODE, DATA} MSB first on din1/din2 with
// a shared sync/sclk, then holds sync high for GAP_CYCLES before pulsing done.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset (aborts a frame immediately)
//   bus     da2_controller_if.slave: start/data1/data2/mode in,
//           busy/done/sync/sclk/din1/din2 out (all outputs registered)
// Parameters:
//   CLK_DIV     system cycles per SCLK half-period (>=1)
//   GAP_CYCLES  cycles of sync high after a frame before done (>=1)
// -----------------------------------------------------------------------------
module da2_controller
  import da2_controller_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  da2_controller_if.slave bus
);

  localparam int            GW   = $clog2(GAP_CYCLES) + 1;
  localparam logic [GW-1:0] GMAX = GW'(GAP_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [DA2_FRAME_W-1:0] sh1_q, sh1_d, sh2_q, sh2_d;
  logic [3:0]             bit_q, bit_d;
  logic                   last_q, last_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   sync_q, sync_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   din1_q, din1_d;
  logic                   din2_q, din2_d;

  logic sclk_en, sclk_rise, sclk_fall;

  assign sclk_en = (state_q == ST_SHIFT);

  da2_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (sclk_en),
    .sclk_o (bus.sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // bit_q counts DAC sample points (falling edges) down from 15 and stops at 0;
  // last_q marks that the 16th bit has been sampled, so the following rising
  // edge closes the frame instead of shifting.
  always_comb begin
    state_d = state_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    bit_d   = bit_q;
    last_d  = last_q;
    gap_d   = gap_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sh1_d   = make_frame(bus.mode, bus.data1);
          sh2_d   = make_frame(bus.mode, bus.data2);
          bit_d   = 4'd15;
          last_d  = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sclk_fall) begin
          if (bit_q == 4'd0) begin
            last_d = 1'b1;
          end else begin
            bit_d = bit_q - 4'd1;
          end
        end
        if (sclk_rise) begin
          if (last_q) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end else begin
            sh1_d = {sh1_q[DA2_FRAME_W-2:0], 1'b0};
            sh2_d = {sh2_q[DA2_FRAME_W-2:0], 1'b0};
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GMAX) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Line outputs follow the next state so they are registered and glitch-free;
    // data moves only when the shift registers do, i.e. on SCLK rising edges.
    sync_d = (state_d != ST_SHIFT);
    busy_d = (state_d != ST_IDLE);
    din1_d = (state_d == ST_SHIFT) && sh1_d[DA2_FRAME_W-1];
    din2_d = (state_d == ST_SHIFT) && sh2_d[DA2_FRAME_W-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sh1_q   <= '0;
      sh2_q   <= '0;
      bit_q   <= '0;
      last_q  <= 1'b0;
      gap_q   <= '0;
      sync_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      din1_q  <= 1'b0;
      din2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      din1_q  <= din1_d;
      din2_q  <= din2_d;
    end
  end

  assign bus.sync = sync_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.din1 = din1_q;
  assign bus.din2 = din2_q;

endmodule

// File: tb/tb_da2_controller.sv
// -----------------------------------------------------------------------------
// tb_da2_controller
// Two controllers share one clock: instance 0 with CLK_DIV=2/GAP_CYCLES=4,
// instance 1 with CLK_DIV=1/GAP_CYCLES=1. Stimulus drives inputs just after
// each rising edge. A reference model decides acceptance from the protocol
// timing rules and pushes expected words and DONE times into queues; the
// monitor samples on falling edges, decodes DIN at SCLK falling edges and
// pops/compares.
// Cycle label s used below = index of the rising edge at which a value would
// be sampled; a START accepted at edge T0 shows SYNC low for labels
// T0+1..T0+32*CLK_DIV and DONE at label T0+32*CLK_DIV+GAP_CYCLES+1.
// -----------------------------------------------------------------------------
module tb_da2_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n_v;
  logic [1:0]  start_v;
  logic [11:0] d1_v   [2];
  logic [11:0] d2_v   [2];
  logic [1:0]  mode_v [2];
  logic [1:0]  sync_v, sclk_v, busy_v, done_v, din1_v, din2_v;

  da2_controller_if bus0 ();
  da2_controller_if bus1 ();

  assign bus0.start = start_v[0];
  assign bus0.data1 = d1_v[0];
  assign bus0.data2 = d2_v[0];
  assign bus0.mode  = mode_v[0];
  assign bus1.start = start_v[1];
  assign bus1.data1 = d1_v[1];
  assign bus1.data2 = d2_v[1];
  assign bus1.mode  = mode_v[1];

  assign sync_v = {bus1.sync, bus0.sync};
  assign sclk_v = {bus1.sclk, bus0.sclk};
  assign busy_v = {bus1.busy, bus0.busy};
  assign done_v = {bus1.done, bus0.done};
  assign din1_v = {bus1.din1, bus0.din1};
  assign din2_v = {bus1.din2, bus0.din2};

  da2_controller #(.CLK_DIV(2), .GAP_CYCLES(4)) u_dut0 (
    .clk_i  (clk),
    .rst_ni (rst_n_v[0]),
    .bus    (bus0)
  );

  da2_controller #(.CLK_DIV(1), .GAP_CYCLES(1)) u_dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n_v[1]),
    .bus    (bus1)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  bit end_req = 1'b0;
  bit mon_done = 1'b0;

  initial forever begin
    @(posedge clk);
    edge_n = edge_n + 1;
  end

  task automatic chk(input int inst, input int s, input bit ok, input string name,
                     input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL dut%0d %s at cycle %0d: actual=%0h required=%0h", inst, name, s, act, req);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  logic [31:0] wq [2][$];
  int          dq [2][$];
  int          nf [2];
  int          t0 [2];
  int          lowc [2];
  int          nb [2];
  int          lastf [2];
  int          nfr [2];
  logic [15:0] c1 [2];
  logic [15:0] c2 [2];
  bit          ps [2];
  bit          pk [2];

  initial begin
    int s, cd, gp;
    bit exp_busy, exp_low;
    for (int i = 0; i < 2; i++) begin
      nf[i] = 0; t0[i] = -1000; lowc[i] = 0; nb[i] = 0; lastf[i] = 0; nfr[i] = 0;
      c1[i] = '0; c2[i] = '0; ps[i] = 1'b1; pk[i] = 1'b1;
    end
    forever begin
      @(negedge clk);
      s = edge_n + 1;
      for (int i = 0; i < 2; i++) begin
        cd = (i == 0) ? 2 : 1;
        gp = (i == 0) ? 4 : 1;
        if (!rst_n_v[i]) begin
          chk(i, s, {sync_v[i], sclk_v[i], busy_v[i], done_v[i], din1_v[i], din2_v[i]} == 6'b110000,
              "reset_outputs",
              {sync_v[i], sclk_v[i], busy_v[i], done_v[i], din1_v[i], din2_v[i]}, 6'b110000);
          wq[i].delete();
          dq[i].delete();
          nf[i] = 0; t0[i] = -1000; lowc[i] = 0; nb[i] = 0;
        end else begin
          exp_busy = (s > t0[i]) && (s < nf[i]);
          chk(i, s, busy_v[i] == exp_busy, "busy", busy_v[i], exp_busy);
          exp_low = (s > t0[i]) && (s <= t0[i] + 32 * cd);
          chk(i, s, sync_v[i] == !exp_low, "sync", sync_v[i], !exp_low);
          if (sync_v[i])
            chk(i, s, {sclk_v[i], din1_v[i], din2_v[i]} == 3'b100, "idle_lines",
                {sclk_v[i], din1_v[i], din2_v[i]}, 3'b100);
          if (done_v[i]) begin
            if (dq[i].size() == 0) begin
              chk(i, s, 1'b0, "done_unexpected", 1, 0);
            end else begin
              int e;
              e = dq[i].pop_front();
              chk(i, s, s == e, "done_time", s, e);
            end
          end
          if (!sync_v[i]) begin
            lowc[i]++;
            if (pk[i] && !sclk_v[i]) begin
              if (nb[i] > 0)
                chk(i, s, (s - lastf[i]) == 2 * cd, "sclk_period", s - lastf[i], 2 * cd);
              lastf[i] = s;
              c1[i] = {c1[i][14:0], din1_v[i]};
              c2[i] = {c2[i][14:0], din2_v[i]};
              nb[i]++;
            end
          end else if (!ps[i]) begin
            chk(i, s, lowc[i] == 32 * cd, "sync_low_len", lowc[i], 32 * cd);
            chk(i, s, nb[i] == 16, "fall_count", nb[i], 16);
            if (wq[i].size() == 0) begin
              chk(i, s, 1'b0, "frame_unexpected", 1, 0);
            end else begin
              logic [31:0] w;
              w = wq[i].pop_front();
              chk(i, s, c1[i] == w[31:16], "word1", c1[i], w[31:16]);
              chk(i, s, c2[i] == w[15:0], "word2", c2[i], w[15:0]);
              nfr[i]++;
            end
            lowc[i] = 0;
            nb[i] = 0;
          end
          // Acceptance at the coming edge: idle or in the DONE cycle.
          if (start_v[i] && s >= nf[i]) begin
            t0[i] = s;
            nf[i] = s + 32 * cd + gp + 1;
            wq[i].push_back({2'b00, mode_v[i], d1_v[i], 2'b00, mode_v[i], d2_v[i]});
            dq[i].push_back(nf[i]);
          end
        end
        ps[i] = sync_v[i];
        pk[i] = sclk_v[i];
      end
      if (end_req && !mon_done) begin
        for (int i = 0; i < 2; i++) begin
          chk(i, s, wq[i].size() == 0, "frames_missing", wq[i].size(), 0);
          chk(i, s, dq[i].size() == 0, "done_missing", dq[i].size(), 0);
        end
        chk(0, s, nfr[0] >= 10, "frame_total", nfr[0], 10);
        chk(1, s, nfr[1] >= 4, "frame_total", nfr[1], 4);
        mon_done = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rnd(input int i);
    d1_v[i]   = 12'($urandom);
    d2_v[i]   = 12'($urandom);
    mode_v[i] = 2'($urandom);
  endtask

  task automatic tickr(input int i, input int n);
    repeat (n) begin
      rnd(i);
      tick(1);
    end
  endtask

  task automatic pulse(input int i);
    start_v[i] = 1'b1;
    tick(1);
    start_v[i] = 1'b0;
  endtask

  initial begin
    rst_n_v = 2'b00;
    start_v = 2'b00;
    for (int i = 0; i < 2; i++) begin
      d1_v[i] = '0; d2_v[i] = '0; mode_v[i] = '0;
    end
    tick(3);
    rst_n_v = 2'b11;
    tick(2);

    // basic frame
    d1_v[0] = 12'hA5C; d2_v[0] = 12'h3F0; mode_v[0] = 2'b00;
    pulse(0);
    tick(75);

    // all ones with high-Z power-down
    d1_v[0] = 12'hFFF; d2_v[0] = 12'hFFF; mode_v[0] = 2'b11;
    pulse(0);
    tick(75);

    // START held high: back-to-back frames, inputs changing every cycle
    start_v[0] = 1'b1;
    tickr(0, 300);
    start_v[0] = 1'b0;
    tickr(0, 75);

    // extra STARTs and DATA1 change during SHIFT are ignored
    rnd(0);
    pulse(0);
    tick(5);
    d1_v[0] = 12'h123;
    repeat (3) begin
      pulse(0);
      tick(6);
    end
    tick(60);

    // reset during bit 8, then a clean frame
    rnd(0);
    pulse(0);
    tick(33);
    rst_n_v[0] = 1'b0;
    tick(2);
    rst_n_v[0] = 1'b1;
    tick(3);
    rnd(0);
    pulse(0);
    tick(75);

    // random starts with random spacing
    repeat (15) begin
      rnd(0);
      start_v[0] = 1'b1;
      tickr(0, $urandom_range(1, 3));
      start_v[0] = 1'b0;
      tickr(0, $urandom_range(0, 80));
    end
    tick(80);

    // fastest configuration
    d1_v[1] = 12'h001; d2_v[1] = 12'h800; mode_v[1] = 2'b00;
    pulse(1);
    tick(40);
    repeat (12) begin
      rnd(1);
      start_v[1] = 1'b1;
      tickr(1, $urandom_range(1, 3));
      start_v[1] = 1'b0;
      tickr(1, $urandom_range(0, 40));
    end
    tick(40);

    end_req = 1'b1;
    for (int k = 0; k < 10 && !mon_done; k++) @(negedge clk);
    if (!mon_done) begin
      $display("FAIL monitor_end: actual=not finished required=finished");
      $fatal(1, "monitor did not complete");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
